// File: rtl/msg_frame_assembler.sv
// Receive-side framer: packs an MSB-first byte stream into cmd/addr/data packets
// and presents them on a valid/ready port, with timeout, overrun and error counting.
module msg_frame_assembler #(
  parameter int CMD_WIDTH      = 5,
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_COMMANDS   = 5,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  msg_valid,
  input  logic                  msg_ready,
  output logic [CMD_WIDTH-1:0]  msg_cmd,
  output logic [ADDR_WIDTH-1:0] msg_addr,
  output logic [DATA_WIDTH-1:0] msg_data,
  output logic                  msg_cmd_err,
  output logic                  timeout_err,
  output logic                  overrun_err,
  output logic [7:0]            err_count
);

  localparam int PACKET_WIDTH = CMD_WIDTH + 3 + ADDR_WIDTH + DATA_WIDTH;
  localparam int NUM_BYTES    = PACKET_WIDTH / 8;
  localparam int CNT_W        = $clog2(NUM_BYTES + 1);
  localparam int IDLE_W       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [CNT_W-1:0]  LAST_COUNT = CNT_W'(NUM_BYTES);
  localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(TIMEOUT_CYCLES - 1);

  generate
    if (PACKET_WIDTH % 8 != 0) begin : g_bad_packet_width
      $error("msg_frame_assembler: packet width must be a whole number of bytes");
    end
  endgenerate

  typedef enum logic {S_IDLE, S_ASSEMBLE} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        byte_count_q, byte_count_d;
  logic [IDLE_W-1:0]       idle_cnt_q, idle_cnt_d;
  logic [PACKET_WIDTH-1:0] shift_q, shift_d;
  logic                    msg_valid_q, msg_valid_d;
  logic [CMD_WIDTH-1:0]    msg_cmd_q, msg_cmd_d;
  logic [ADDR_WIDTH-1:0]   msg_addr_q, msg_addr_d;
  logic [DATA_WIDTH-1:0]   msg_data_q, msg_data_d;
  logic                    msg_cmd_err_q, msg_cmd_err_d;
  logic                    timeout_err_q, timeout_err_d;
  logic                    overrun_err_q, overrun_err_d;
  logic [7:0]              err_count_q, err_count_d;

  logic [PACKET_WIDTH-1:0] packet;
  logic [CMD_WIDTH-1:0]    new_cmd;
  logic                    handshake;
  logic                    cmd_err_taken;
  logic [8:0]              err_sum;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d       = state_q;
    byte_count_d  = byte_count_q;
    idle_cnt_d    = idle_cnt_q;
    shift_d       = shift_q;
    msg_valid_d   = msg_valid_q;
    msg_cmd_d     = msg_cmd_q;
    msg_addr_d    = msg_addr_q;
    msg_data_d    = msg_data_q;
    msg_cmd_err_d = msg_cmd_err_q;
    timeout_err_d = 1'b0;
    overrun_err_d = 1'b0;

    packet        = (shift_q << 8) | PACKET_WIDTH'(byte_data);
    new_cmd       = packet[PACKET_WIDTH-1 -: CMD_WIDTH];
    handshake     = msg_valid_q && msg_ready;
    cmd_err_taken = handshake && msg_cmd_err_q;

    if (handshake) msg_valid_d = 1'b0;

    if (flush) begin
      state_d      = S_IDLE;
      byte_count_d = '0;
      idle_cnt_d   = '0;
    end else if (byte_valid) begin
      shift_d    = packet;
      idle_cnt_d = '0;
      if (byte_count_q + CNT_W'(1) == LAST_COUNT) begin
        state_d      = S_IDLE;
        byte_count_d = '0;
        // A packet completing against a held, unaccepted one is dropped.
        if (!msg_valid_q || msg_ready) begin
          msg_valid_d   = 1'b1;
          msg_cmd_d     = new_cmd;
          msg_addr_d    = packet[DATA_WIDTH +: ADDR_WIDTH];
          msg_data_d    = packet[DATA_WIDTH-1:0];
          msg_cmd_err_d = (32'(new_cmd) >= 32'(NUM_COMMANDS));
        end else begin
          overrun_err_d = 1'b1;
        end
      end else begin
        state_d      = S_ASSEMBLE;
        byte_count_d = byte_count_q + CNT_W'(1);
      end
    end else if (state_q == S_ASSEMBLE) begin
      if (idle_cnt_q == IDLE_LIMIT) begin
        state_d       = S_IDLE;
        byte_count_d  = '0;
        idle_cnt_d    = '0;
        timeout_err_d = 1'b1;
      end else begin
        idle_cnt_d = idle_cnt_q + IDLE_W'(1);
      end
    end

    err_sum     = {1'b0, err_count_q} + {8'd0, timeout_err_d}
                + {8'd0, overrun_err_d} + {8'd0, cmd_err_taken};
    err_count_d = err_sum[8] ? 8'hFF : err_sum[7:0];
  end

  // NOTE: shift_q is left out of reset: stale bits are shifted out before any
  // packet completes, so its contents are never observed.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      byte_count_q  <= '0;
      idle_cnt_q    <= '0;
      msg_valid_q   <= 1'b0;
      msg_cmd_q     <= '0;
      msg_addr_q    <= '0;
      msg_data_q    <= '0;
      msg_cmd_err_q <= 1'b0;
      timeout_err_q <= 1'b0;
      overrun_err_q <= 1'b0;
      err_count_q   <= '0;
    end else begin
      state_q       <= state_d;
      byte_count_q  <= byte_count_d;
      idle_cnt_q    <= idle_cnt_d;
      msg_valid_q   <= msg_valid_d;
      msg_cmd_q     <= msg_cmd_d;
      msg_addr_q    <= msg_addr_d;
      msg_data_q    <= msg_data_d;
      msg_cmd_err_q <= msg_cmd_err_d;
      timeout_err_q <= timeout_err_d;
      overrun_err_q <= overrun_err_d;
      err_count_q   <= err_count_d;
    end
  end

  assign msg_valid   = msg_valid_q;
  assign msg_cmd     = msg_cmd_q;
  assign msg_addr    = msg_addr_q;
  assign msg_data    = msg_data_q;
  assign msg_cmd_err = msg_cmd_err_q;
  assign timeout_err = timeout_err_q;
  assign overrun_err = overrun_err_q;
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_msg_frame_assembler.sv
// Bench for msg_frame_assembler: a 48-bit build (short timeout) and an 88-bit build,
// driven by a vector table, hand-written corner sequences and a randomized model run.
module tb_msg_frame_assembler;

  logic clk = 1'b0;
  logic reset;

  logic        a_flush, a_bv, a_ready;
  logic [7:0]  a_bd;
  logic        a_valid, a_cmd_err, a_to, a_ov;
  logic [4:0]  a_cmd;
  logic [7:0]  a_addr, a_errc;
  logic [31:0] a_data;

  logic        b_flush, b_bv, b_ready;
  logic [7:0]  b_bd;
  logic        b_valid, b_cmd_err, b_to, b_ov;
  logic [4:0]  b_cmd;
  logic [15:0] b_addr;
  logic [63:0] b_data;
  logic [7:0]  b_errc;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  msg_frame_assembler #(.TIMEOUT_CYCLES(8)) dut_a (
    .clk(clk), .reset(reset), .flush(a_flush), .byte_valid(a_bv), .byte_data(a_bd),
    .msg_valid(a_valid), .msg_ready(a_ready), .msg_cmd(a_cmd), .msg_addr(a_addr),
    .msg_data(a_data), .msg_cmd_err(a_cmd_err), .timeout_err(a_to),
    .overrun_err(a_ov), .err_count(a_errc)
  );

  msg_frame_assembler #(.ADDR_WIDTH(16), .DATA_WIDTH(64), .TIMEOUT_CYCLES(8)) dut_b (
    .clk(clk), .reset(reset), .flush(b_flush), .byte_valid(b_bv), .byte_data(b_bd),
    .msg_valid(b_valid), .msg_ready(b_ready), .msg_cmd(b_cmd), .msg_addr(b_addr),
    .msg_data(b_data), .msg_cmd_err(b_cmd_err), .timeout_err(b_to),
    .overrun_err(b_ov), .err_count(b_errc)
  );

  typedef struct {
    logic [47:0] pkt;
    logic [4:0]  cmd;
    logic [7:0]  addr;
    logic [31:0] data;
    logic        cmd_err;
  } vec_t;

  vec_t vecs [6];

  localparam logic [47:0] P1 = 48'h08_2A_DEADBEEF;  // cmd 1
  localparam logic [47:0] P2 = 48'h10_55_CAFEF00D;  // cmd 2
  localparam logic [47:0] PE = 48'h38_11_12345678;  // cmd 7, illegal

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_flush = 0; a_bv = 0; a_bd = 0;
    b_flush = 0; b_bv = 0; b_bd = 0;
    reset = 1;
    tick();
    reset = 0;
  endtask

  task automatic a_send(input logic [7:0] b);
    a_bv = 1;
    a_bd = b;
    tick();
    a_bv = 0;
  endtask

  task automatic a_send_pkt(input logic [47:0] p);
    for (int i = 5; i >= 0; i--) a_send(8'(p >> (8 * i)));
  endtask

  task automatic b_send(input logic [7:0] b);
    b_bv = 1;
    b_bd = b;
    tick();
    b_bv = 0;
  endtask

  task automatic a_expect(input string tag, input logic [47:0] p, input logic err);
    check({tag, "_valid"}, a_valid, 1'b1);
    check({tag, "_cmd"}, a_cmd, p[47:43]);
    check({tag, "_addr"}, a_addr, p[39:32]);
    check({tag, "_data"}, a_data, p[31:0]);
    check({tag, "_cmd_err"}, a_cmd_err, err);
  endtask

  initial begin
    logic [7:0] pb [11];
    int exp_err;
    logic seen;

    vecs[0] = '{48'h08_2A_DEADBEEF, 5'd1,  8'h2A, 32'hDEADBEEF, 1'b0};
    vecs[1] = '{48'h38_11_12345678, 5'd7,  8'h11, 32'h12345678, 1'b1};
    vecs[2] = '{48'h27_FF_FFFFFFFF, 5'd4,  8'hFF, 32'hFFFFFFFF, 1'b0};
    vecs[3] = '{48'h28_00_00000001, 5'd5,  8'h00, 32'h00000001, 1'b1};
    vecs[4] = '{48'hF8_80_80000000, 5'd31, 8'h80, 32'h80000000, 1'b1};
    vecs[5] = '{48'h00_00_00000000, 5'd0,  8'h00, 32'h00000000, 1'b0};
    pb = '{8'h1D, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF};

    a_flush = 0; a_bv = 0; a_bd = 0; a_ready = 0;
    b_flush = 0; b_bv = 0; b_bd = 0; b_ready = 0;
    reset = 1;
    tick();
    tick();
    check("rst_valid", a_valid, 0);
    check("rst_fields", {a_cmd, a_addr, a_data}, 0);
    check("rst_errs", {a_cmd_err, a_to, a_ov, a_errc}, 0);
    check("rst_b_state", {b_valid, b_cmd_err, b_to, b_ov, b_errc}, 0);
    reset = 0;
    a_ready = 1;
    b_ready = 1;

    // Vector table, consumer always ready
    exp_err = 0;
    foreach (vecs[i]) begin
      a_send_pkt(vecs[i].pkt);
      check("vec_valid", a_valid, 1'b1);
      check("vec_cmd", a_cmd, vecs[i].cmd);
      check("vec_addr", a_addr, vecs[i].addr);
      check("vec_data", a_data, vecs[i].data);
      check("vec_cmd_err", a_cmd_err, vecs[i].cmd_err);
      tick();
      if (vecs[i].cmd_err) exp_err++;
      check("vec_drop", a_valid, 1'b0);
      check("vec_err_count", a_errc, 8'(exp_err));
    end

    // Back-to-back packets with no gap
    a_send_pkt(P1);
    a_expect("b2b_first", P1, 1'b0);
    a_send_pkt(P2);
    a_expect("b2b_second", P2, 1'b0);
    tick();
    check("b2b_drop", a_valid, 1'b0);

    // Timeout after 8 idle cycles, then a clean packet
    do_reset();
    a_send(8'h11); a_send(8'h22); a_send(8'h33);
    seen = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      seen |= a_to;
    end
    check("to_early", seen, 1'b0);
    tick();
    check("to_pulse", a_to, 1'b1);
    check("to_err_count", a_errc, 8'd1);
    tick();
    check("to_single", a_to, 1'b0);
    a_send_pkt(P1);
    a_expect("after_to", P1, 1'b0);
    tick();

    // Byte arriving in the timeout cycle cancels the timeout
    do_reset();
    a_send(P2[47:40]); a_send(P2[39:32]); a_send(P2[31:24]);
    seen = 0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      seen |= a_to;
    end
    a_send(P2[23:16]);
    seen |= a_to;
    check("to_cancel", seen, 1'b0);
    a_send(P2[15:8]); a_send(P2[7:0]);
    a_expect("to_cancel_pkt", P2, 1'b0);
    check("to_cancel_err_count", a_errc, 8'd0);
    tick();

    // Timeout coinciding with acceptance of an illegal-command packet counts twice
    do_reset();
    a_ready = 0;
    a_send_pkt(PE);
    a_expect("coinc_held", PE, 1'b1);
    a_send(8'h01); a_send(8'h02); a_send(8'h03);
    for (int k = 1; k <= 7; k++) tick();
    a_ready = 1;
    tick();
    check("coinc_to", a_to, 1'b1);
    check("coinc_valid", a_valid, 1'b0);
    check("coinc_err_count", a_errc, 8'd2);

    // Overrun: second packet dropped while first is held
    do_reset();
    a_ready = 0;
    a_send_pkt(P1);
    a_expect("ovr_first", P1, 1'b0);
    a_send_pkt(P2);
    check("ovr_pulse", a_ov, 1'b1);
    a_expect("ovr_held", P1, 1'b0);
    check("ovr_err_count", a_errc, 8'd1);
    tick();
    check("ovr_single", a_ov, 1'b0);
    a_ready = 1;
    tick();
    check("ovr_drop", a_valid, 1'b0);
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      seen |= a_valid;
    end
    check("ovr_no_second", seen, 1'b0);
    check("ovr_err_final", a_errc, 8'd1);

    // Flush with a byte present discards partial packet and that byte
    do_reset();
    a_send(8'h08); a_send(8'h2A); a_send(8'hDE);
    a_flush = 1; a_bv = 1; a_bd = 8'h08;
    tick();
    a_flush = 0; a_bv = 0;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      seen |= a_to | a_valid;
    end
    check("flush_quiet", seen, 1'b0);
    a_send_pkt(P1);
    a_expect("flush_pkt", P1, 1'b0);
    check("flush_err_count", a_errc, 8'd0);
    tick();

    // Asynchronous reset mid-packet while an overrun-counted packet is held
    do_reset();
    a_ready = 0;
    a_send_pkt(PE);
    a_send_pkt(P2);
    check("arst_pre_err", a_errc, 8'd1);
    tick();
    a_send(8'h08); a_send(8'h2A); a_send(8'hDE);
    a_bv = 1; a_bd = 8'hAD;
    #2;
    reset = 1;
    #1;
    check("arst_valid", a_valid, 0);
    check("arst_fields", {a_cmd, a_addr, a_data}, 0);
    check("arst_errs", {a_cmd_err, a_to, a_ov, a_errc}, 0);
    tick();
    reset = 0; a_bv = 0; a_ready = 1;
    a_send_pkt(P1);
    a_expect("arst_pkt", P1, 1'b0);
    tick();

    // 88-bit build: decode, then a 10-byte fragment flushed
    do_reset();
    foreach (pb[i]) b_send(pb[i]);
    check("b_valid", b_valid, 1'b1);
    check("b_cmd", b_cmd, 5'd3);
    check("b_addr", b_addr, 16'hBEEF);
    check("b_data", b_data, 64'h0123456789ABCDEF);
    check("b_cmd_err", b_cmd_err, 1'b0);
    tick();
    for (int i = 0; i < 10; i++) b_send(8'hA5);
    b_flush = 1; b_bv = 1; b_bd = 8'hFF;
    tick();
    b_flush = 0; b_bv = 0;
    seen = b_valid;
    for (int i = 0; i < 10; i++) begin
      b_send(pb[i]);
      seen |= b_valid | b_to;
    end
    check("b_flush_quiet", seen, 1'b0);
    b_send(pb[10]);
    check("b_flush_pkt", {b_valid, b_cmd, b_addr}, {1'b1, 5'd3, 16'hBEEF});
    check("b_flush_data", b_data, 64'h0123456789ABCDEF);
    check("b_flush_errs", {b_to, b_ov, b_errc}, 0);

    // Randomized run against a byte-queue reference model
    do_reset();
    begin
      logic [7:0]  part [$];
      logic [47:0] m_pkt, pkt;
      logic        m_valid, m_to, m_ov, free;
      int          quiet, m_err, inc, gap, stall;
      m_pkt = 0; m_valid = 0; m_to = 0; m_ov = 0;
      quiet = 0; m_err = 0; gap = 0; stall = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
        a_flush = ($urandom_range(0, 59) == 0);
        if (gap > 0) begin
          a_bv = 0;
          gap--;
        end else begin
          a_bv = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 79) == 0) gap = $urandom_range(4, 12);
        end
        a_bd = 8'($urandom);
        if (stall > 0) begin
          a_ready = 0;
          stall--;
        end else begin
          a_ready = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 99) == 0) stall = $urandom_range(5, 20);
        end
        tick();

        m_to = 0; m_ov = 0; inc = 0;
        free = !m_valid || a_ready;
        if (m_valid && a_ready) begin
          if (m_pkt[47:43] >= 5) inc++;
          m_valid = 0;
        end
        if (a_flush) begin
          part.delete();
          quiet = 0;
        end else if (a_bv) begin
          part.push_back(a_bd);
          quiet = 0;
          if (part.size() == 6) begin
            pkt = 0;
            foreach (part[i]) pkt = (pkt << 8) | 48'(part[i]);
            part.delete();
            if (free) begin
              m_valid = 1;
              m_pkt = pkt;
            end else begin
              m_ov = 1;
              inc++;
            end
          end
        end else if (part.size() > 0) begin
          quiet++;
          if (quiet == 8) begin
            part.delete();
            quiet = 0;
            m_to = 1;
            inc++;
          end
        end
        m_err = (m_err + inc > 255) ? 255 : m_err + inc;

        check("rand_cycle",
              {a_valid, a_cmd, a_addr, a_data, a_cmd_err, a_to, a_ov, a_errc},
              {m_valid, m_pkt[47:43], m_pkt[39:32], m_pkt[31:0],
               (m_pkt[47:43] >= 5'd5), m_to, m_ov, 8'(m_err)});
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
